// File: rtl/ts_defs.sv
// Shared transport-stream definitions.
// Default packet geometry, sync byte value and the aligner state encodings.
// The downstream RAM wrapper imports the same package.
package ts_defs;

   localparam int unsigned TS_PACKET_LEN = 188;
   localparam logic [7:0]  TS_SYNC_BYTE  = 8'h47;

   localparam logic [1:0] ST_HUNT   = 2'd0;
   localparam logic [1:0] ST_VERIFY = 2'd1;
   localparam logic [1:0] ST_LOCKED = 2'd2;

   typedef enum logic [1:0] {
      StHunt   = ST_HUNT,
      StVerify = ST_VERIFY,
      StLocked = ST_LOCKED
   } ts_state_e;

endpackage

// File: rtl/ts_sync_aligner.sv
// Transport-stream packet aligner (mpeg_clk domain).
// Hunts for SYNC_BYTE at PACKET_LEN spacing, locks after LOCK_COUNT consecutive
// correctly spaced hits, drops lock after UNLOCK_COUNT consecutive misses, and
// forwards bytes only while locked. All outputs are registered (1 cycle latency).
//
// Ports:
//   mpeg_clk       byte clock
//   mpeg_rst       synchronous, active-high reset
//   in_data        raw TS byte
//   in_valid       in_data qualifier
//   mpeg_data      aligned byte (follows in_data every cycle)
//   mpeg_valid     aligned byte valid, only while locked
//   mpeg_sync      first byte of each forwarded packet
//   locked         lock status
//   sync_loss_cnt  saturating count of lock-loss events
module ts_sync_aligner
   import ts_defs::*;
#(
   parameter int unsigned PACKET_LEN   = TS_PACKET_LEN,
   parameter logic [7:0]  SYNC_BYTE    = TS_SYNC_BYTE,
   parameter int unsigned LOCK_COUNT   = 3,
   parameter int unsigned UNLOCK_COUNT = 3
) (
   input  logic        mpeg_clk,
   input  logic        mpeg_rst,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic [7:0]  mpeg_data,
   output logic        mpeg_valid,
   output logic        mpeg_sync,
   output logic        locked,
   output logic [15:0] sync_loss_cnt
);

   localparam logic [7:0] LastByte  = 8'(PACKET_LEN - 1);
   localparam logic [7:0] LockCnt   = 8'(LOCK_COUNT);
   localparam logic [7:0] UnlockCnt = 8'(UNLOCK_COUNT);

   ts_state_e   state_q, state_d;
   logic [7:0]  byte_cnt_q, byte_cnt_d;
   logic [7:0]  hit_cnt_q, hit_cnt_d;
   logic [7:0]  miss_cnt_q, miss_cnt_d;
   logic [15:0] sync_loss_cnt_q, sync_loss_cnt_d;
   logic [7:0]  mpeg_data_q, mpeg_data_d;
   logic        mpeg_valid_q, mpeg_valid_d;
   logic        mpeg_sync_q, mpeg_sync_d;

   logic       fwd;
   logic       at_sync;
   logic       sync_pos;
   logic       sync_hit;
   logic [7:0] hit_inc;
   logic [7:0] miss_inc;

   always_comb begin
      state_d         = state_q;
      byte_cnt_d      = byte_cnt_q;
      hit_cnt_d       = hit_cnt_q;
      miss_cnt_d      = miss_cnt_q;
      sync_loss_cnt_d = sync_loss_cnt_q;
      fwd             = 1'b0;
      at_sync         = (byte_cnt_q == 8'd0);
      sync_pos        = in_valid && (byte_cnt_q == 8'd0);
      sync_hit        = (in_data == SYNC_BYTE);
      hit_inc         = hit_cnt_q + 8'd1;
      miss_inc        = miss_cnt_q + 8'd1;

      // Spacing is measured in valid bytes only.
      if (in_valid) begin
         byte_cnt_d = (byte_cnt_q == LastByte) ? 8'd0 : byte_cnt_q + 8'd1;
      end

      unique case (state_q)
         StHunt: begin
            if (in_valid && sync_hit) begin
               byte_cnt_d = 8'd1;
               hit_cnt_d  = 8'd1;
               miss_cnt_d = 8'd0;
               if (LOCK_COUNT == 1) begin
                  // byte_cnt is meaningless while hunting, so flag the sync explicitly.
                  state_d = StLocked;
                  fwd     = 1'b1;
                  at_sync = 1'b1;
               end else begin
                  state_d = StVerify;
               end
            end
         end
         StVerify: begin
            if (sync_pos) begin
               if (sync_hit) begin
                  hit_cnt_d = hit_inc;
                  if (hit_inc == LockCnt) begin
                     state_d    = StLocked;
                     miss_cnt_d = 8'd0;
                     // Forward the locking sync byte so downstream sees whole packets.
                     fwd        = 1'b1;
                  end
               end else begin
                  state_d = StHunt;
               end
            end
         end
         StLocked: begin
            fwd = 1'b1;
            if (sync_pos) begin
               if (sync_hit) begin
                  miss_cnt_d = 8'd0;
               end else begin
                  miss_cnt_d = miss_inc;
                  if (miss_inc == UnlockCnt) begin
                     state_d = StHunt;
                     fwd     = 1'b0;
                     if (sync_loss_cnt_q != 16'hFFFF) begin
                        sync_loss_cnt_d = sync_loss_cnt_q + 16'd1;
                     end
                  end
               end
            end
         end
         default: state_d = StHunt;
      endcase

      mpeg_data_d  = in_data;
      mpeg_valid_d = in_valid && fwd;
      mpeg_sync_d  = in_valid && fwd && at_sync;
   end

   always_ff @(posedge mpeg_clk) begin
      if (mpeg_rst) begin
         state_q         <= StHunt;
         byte_cnt_q      <= 8'd0;
         hit_cnt_q       <= 8'd0;
         miss_cnt_q      <= 8'd0;
         sync_loss_cnt_q <= 16'd0;
         mpeg_data_q     <= 8'd0;
         mpeg_valid_q    <= 1'b0;
         mpeg_sync_q     <= 1'b0;
      end else begin
         state_q         <= state_d;
         byte_cnt_q      <= byte_cnt_d;
         hit_cnt_q       <= hit_cnt_d;
         miss_cnt_q      <= miss_cnt_d;
         sync_loss_cnt_q <= sync_loss_cnt_d;
         mpeg_data_q     <= mpeg_data_d;
         mpeg_valid_q    <= mpeg_valid_d;
         mpeg_sync_q     <= mpeg_sync_d;
      end
   end

   assign mpeg_data     = mpeg_data_q;
   assign mpeg_valid    = mpeg_valid_q;
   assign mpeg_sync     = mpeg_sync_q;
   assign locked        = (state_q == StLocked);
   assign sync_loss_cnt = sync_loss_cnt_q;

endmodule

// File: tb/tb_ts_sync_aligner.sv
// Directed bench for ts_sync_aligner with 188-byte packets and default counts.
module tb_ts_sync_aligner;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  in_data = 8'd0;
   logic        in_valid = 1'b0;
   logic [7:0]  mpeg_data;
   logic        mpeg_valid;
   logic        mpeg_sync;
   logic        locked;
   logic [15:0] sync_loss_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   // Per-scenario observations, indexed by valid input byte.
   int vidx, n_val, n_sync, first_sync, last_sync, lock_rise, lock_fall, data_err, idle_err;

   ts_sync_aligner dut (
      .mpeg_clk      (clk),
      .mpeg_rst      (rst),
      .in_data       (in_data),
      .in_valid      (in_valid),
      .mpeg_data     (mpeg_data),
      .mpeg_valid    (mpeg_valid),
      .mpeg_sync     (mpeg_sync),
      .locked        (locked),
      .sync_loss_cnt (sync_loss_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] payload(input int i);
      logic [7:0] b;
      b = 8'(i);
      if (b == 8'h47) b = 8'h48;
      return b;
   endfunction

   task automatic clear_stats();
      vidx = 0; n_val = 0; n_sync = 0; first_sync = -1; last_sync = -1;
      lock_rise = -1; lock_fall = -1; data_err = 0; idle_err = 0;
   endtask

   // One clock: drive a byte, then observe its registered result 1 ns after the edge.
   task automatic step(input logic [7:0] d, input logic v);
      logic prev_locked;
      prev_locked = locked;
      in_data  = d;
      in_valid = v;
      @(posedge clk);
      #1;
      if (v) begin
         if (mpeg_valid) begin
            n_val++;
            if (mpeg_data !== d) data_err++;
         end
         if (mpeg_sync) begin
            n_sync++;
            if (first_sync < 0) first_sync = vidx;
            last_sync = vidx;
         end
         if (locked && !prev_locked) lock_rise = vidx;
         if (!locked && prev_locked) lock_fall = vidx;
         vidx++;
      end else if (mpeg_valid || mpeg_sync) begin
         idle_err++;
      end
   endtask

   task automatic send_pkt(input logic [7:0] sync_val, input bit gaps);
      for (int i = 0; i < 188; i++) begin
         if (gaps) begin
            while ($urandom_range(99) < 30) step(8'h00, 1'b0);
         end
         step((i == 0) ? sync_val : payload(i), 1'b1);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(8'h00, 1'b0);
      step(8'h00, 1'b0);
      rst = 1'b0;
   endtask

   task automatic lock_up();
      for (int p = 0; p < 3; p++) send_pkt(8'h47, 1'b0);
   endtask

   initial begin
      // Reset state
      rst = 1'b1;
      step(8'h5A, 1'b1);
      step(8'h47, 1'b1);
      rst = 1'b0;
      check("rst_data", 32'(mpeg_data), 32'h0);
      check("rst_valid", 32'(mpeg_valid), 32'h0);
      check("rst_sync", 32'(mpeg_sync), 32'h0);
      check("rst_locked", 32'(locked), 32'h0);
      check("rst_loss", 32'(sync_loss_cnt), 32'h0);

      // Clean stream: lock on third sync at valid byte 376
      clear_stats();
      for (int p = 0; p < 5; p++) send_pkt(8'h47, 1'b0);
      check("clean_lock_rise", 32'(lock_rise), 32'd376);
      check("clean_first_sync", 32'(first_sync), 32'd376);
      check("clean_last_sync", 32'(last_sync), 32'd752);
      check("clean_n_sync", 32'(n_sync), 32'd3);
      check("clean_n_valid", 32'(n_val), 32'd564);
      check("clean_data", 32'(data_err), 32'd0);
      check("clean_locked", 32'(locked), 32'd1);

      // Same stream with ~30% idle cycles: identical positions in valid bytes
      do_reset();
      clear_stats();
      for (int p = 0; p < 5; p++) send_pkt(8'h47, 1'b1);
      check("gap_lock_rise", 32'(lock_rise), 32'd376);
      check("gap_first_sync", 32'(first_sync), 32'd376);
      check("gap_last_sync", 32'(last_sync), 32'd752);
      check("gap_n_sync", 32'(n_sync), 32'd3);
      check("gap_n_valid", 32'(n_val), 32'd564);
      check("gap_idle", 32'(idle_err), 32'd0);
      check("gap_data", 32'(data_err), 32'd0);

      // False 0x47 at index 138 (50 bytes before the real sync at 188).
      // VERIFY fails at 326, then real syncs at 376/564/752 lock.
      do_reset();
      clear_stats();
      for (int i = 0; i < 188; i++) step((i == 138) ? 8'h47 : payload(i), 1'b1);
      for (int p = 0; p < 5; p++) send_pkt(8'h47, 1'b0);
      check("false_lock_rise", 32'(lock_rise), 32'd752);
      check("false_first_sync", 32'(first_sync), 32'd752);
      check("false_n_sync", 32'(n_sync), 32'd2);
      check("false_n_valid", 32'(n_val), 32'd376);

      // Corruption: 2 misses, good, then 3 misses drops lock at valid byte 940
      do_reset();
      lock_up();
      clear_stats();
      send_pkt(8'h00, 1'b0);
      send_pkt(8'h00, 1'b0);
      check("miss2_locked", 32'(locked), 32'd1);
      send_pkt(8'h47, 1'b0);
      send_pkt(8'h00, 1'b0);
      send_pkt(8'h00, 1'b0);
      check("miss2b_locked", 32'(locked), 32'd1);
      send_pkt(8'h00, 1'b0);
      send_pkt(8'h47, 1'b0);
      check("miss_lock_fall", 32'(lock_fall), 32'd940);
      check("miss_n_valid", 32'(n_val), 32'd940);
      check("miss_n_sync", 32'(n_sync), 32'd5);
      check("miss_last_sync", 32'(last_sync), 32'd752);
      check("miss_data", 32'(data_err), 32'd0);
      check("miss_loss", 32'(sync_loss_cnt), 32'd1);
      check("miss_locked", 32'(locked), 32'd0);

      // Reset at byte 100 of a locked packet
      do_reset();
      lock_up();
      for (int i = 0; i < 100; i++) step((i == 0) ? 8'h47 : payload(i), 1'b1);
      check("pre_rst_locked", 32'(locked), 32'd1);
      rst = 1'b1;
      step(payload(100), 1'b1);
      rst = 1'b0;
      check("mid_rst_data", 32'(mpeg_data), 32'h0);
      check("mid_rst_valid", 32'(mpeg_valid), 32'h0);
      check("mid_rst_sync", 32'(mpeg_sync), 32'h0);
      check("mid_rst_locked", 32'(locked), 32'h0);
      clear_stats();
      for (int p = 0; p < 4; p++) send_pkt(8'h47, 1'b0);
      check("relock_rise", 32'(lock_rise), 32'd376);
      check("relock_n_sync", 32'(n_sync), 32'd2);

      // Loss counter saturation from 16'hFFFE over three lock losses
      do_reset();
      lock_up();
      @(negedge clk);
      force dut.sync_loss_cnt_q = 16'hFFFE;
      #1;
      release dut.sync_loss_cnt_q;
      step(8'h00, 1'b0);
      check("sat_preload", 32'(sync_loss_cnt), 32'hFFFE);
      for (int k = 0; k < 3; k++) begin
         if (k > 0) lock_up();
         for (int p = 0; p < 3; p++) send_pkt(8'h00, 1'b0);
         check("sat_unlocked", 32'(locked), 32'd0);
         check("sat_cnt", 32'(sync_loss_cnt), 32'hFFFF);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Safety net against a stalled run.
   initial begin
      #2000000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
